// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port memData memory between the
// write-stage load/store port (port 0, fixed priority) and the instruction
// fetch port (port 1, read-only). A starvation counter forces a fetch grant
// after STARVE_MAX consecutive denied fetch cycles.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   m0Req/m0Write/m0Addr/m0Data  port 0 request, store flag, address, store data
//   m0Gnt                     port 0 granted this cycle (combinational)
//   m0Valid/m0RData           port 0 load response (pulse / held data)
//   m1Req/m1Addr              port 1 read request and address
//   m1Gnt                     port 1 granted this cycle (combinational)
//   m1Valid/m1RData           port 1 read response (pulse / held data)
//   memAddr/memWData/memWrite memory address, write data, write enable
//   memOut                    memory read data, valid one cycle after address
module mem_port_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0Req,
    input  logic          m0Write,
    input  logic [AW-1:0] m0Addr,
    input  logic [DW-1:0] m0Data,
    output logic          m0Gnt,
    output logic          m0Valid,
    output logic [DW-1:0] m0RData,
    input  logic          m1Req,
    input  logic [AW-1:0] m1Addr,
    output logic          m1Gnt,
    output logic          m1Valid,
    output logic [DW-1:0] m1RData,
    output logic [AW-1:0] memAddr,
    output logic [DW-1:0] memWData,
    output logic          memWrite,
    input  logic [DW-1:0] memOut
);

    localparam int unsigned SW = 4;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_P0   = 2'd1,
        TAG_P1   = 2'd2
    } tag_t;

    logic [SW-1:0] starve;
    tag_t          rsp_tag;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
    logic          starve_hit;

    // Grant decision: port 0 wins unless port 1 has waited STARVE_MAX cycles.
    always_comb begin
        starve_hit = (starve == SW'(STARVE_MAX));
        m1Gnt      = !rst && m1Req && (!m0Req || starve_hit);
        m0Gnt      = !rst && m0Req && !(m1Req && starve_hit);
    end

    // Memory mux; the address holds its last driven value when idle.
    always_comb begin
        memAddr  = addr_q;
        memWData = '0;
        memWrite = 1'b0;
        if (m0Gnt) begin
            memAddr  = m0Addr;
            memWData = m0Data;
            memWrite = m0Write;
        end else if (m1Gnt) begin
            memAddr = m1Addr;
        end
    end

    // Responses line up with memOut in the cycle after the grant; the held
    // registers keep the last delivered word between pulses.
    always_comb begin
        m0Valid = (rsp_tag == TAG_P0);
        m1Valid = (rsp_tag == TAG_P1);
        m0RData = m0Valid ? memOut : rdata0_q;
        m1RData = m1Valid ? memOut : rdata1_q;
    end

    // Starvation counter, response tag, held address and read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve   <= '0;
            rsp_tag  <= TAG_NONE;
            addr_q   <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (m1Req && !m1Gnt) begin
                if (!starve_hit) begin
                    starve <= starve + SW'(1);
                end
            end else begin
                starve <= '0;
            end

            if (m0Gnt && !m0Write) begin
                rsp_tag <= TAG_P0;
            end else if (m1Gnt) begin
                rsp_tag <= TAG_P1;
            end else begin
                rsp_tag <= TAG_NONE;
            end

            addr_q <= memAddr;

            if (m0Valid) begin
                rdata0_q <= memOut;
            end
            if (m1Valid) begin
                rdata1_q <= memOut;
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port `memData` memory between the instruction-fetch requester (port 1) and the write stage's load/store requester (port 0). The block decides each cycle which requester drives the memory address, data and write-enable lines, and routes the registered read data back to the requester that issued the read. Port 0 has fixed priority, with a starvation guard that forces a fetch grant after a bounded wait.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `STARVE_MAX`, 4, consecutive denied fetch cycles before port 1 is forced to win (range 1..15)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `m0Req`  in  1  port 0 (write stage) request
- `m0Write`  in  1  port 0: 1 = store, 0 = load
- `m0Addr`  in  AW  port 0 address
- `m0Data`  in  DW  port 0 store data
- `m0Gnt`  out  1  port 0 granted this cycle (combinational)
- `m0Valid`  out  1  port 0 load data valid (registered, 1-cycle pulse)
- `m0RData`  out  DW  port 0 load data, held until the next port 0 load completes
- `m1Req`  in  1  port 1 (fetch) read request
- `m1Addr`  in  AW  port 1 address
- `m1Gnt`  out  1  port 1 granted this cycle (combinational)
- `m1Valid`  out  1  port 1 read data valid (registered, 1-cycle pulse)
- `m1RData`  out  DW  port 1 read data, held until the next port 1 read completes
- `memAddr`  out  AW  to `memData.address`
- `memWData`  out  DW  to `memData.data`
- `memWrite`  out  1  to `memData.iWrite`
- `memOut`  in  DW  from `memData.out`; valid the cycle after the address is presented

## Operation
- Grant decision is combinational from the current requests and the registered starvation counter `starve` (4 bits). `m0Gnt` and `m1Gnt` are never both high.
  - Both requesting and `starve < STARVE_MAX`: port 0 wins.
  - Both requesting and `starve == STARVE_MAX`: port 1 wins.
  - One requesting: that port wins. Neither: no grant.
- Memory mux:
  - Port 0 granted: `memAddr = m0Addr`, `memWData = m0Data`, `memWrite = m0Write`.
  - Port 1 granted: `memAddr = m1Addr`, `memWData = 0`, `memWrite = 0`.
  - No grant: `memAddr` holds its last driven value, `memWData = 0`, `memWrite = 0`.
- Starvation counter:
  - +1 (saturating at `STARVE_MAX`) on each cycle with `m1Req && !m1Gnt`.
  - Cleared on any cycle with `m1Gnt`, or with `!m1Req`.
- Response tracking uses a registered tag `rspTag` with states NONE, P0, P1:
  - P0 on a port 0 grant with `m0Write = 0`.
  - P1 on a port 1 grant.
  - NONE otherwise, including port 0 stores.
- Response delivery, in the cycle after a grant:
  - Tag P0: `m0Valid = 1` and `m0RData` captures `memOut`.
  - Tag P1: `m1Valid = 1` and `m1RData` captures `memOut`.
  - Port 0 stores produce no `Valid` pulse. The store is committed at the grant edge.
- Requesters hold `Req`, address and data stable until they see `Gnt`. A request is accepted exactly in the cycle `Gnt` is high. A requester may re-request back-to-back.

## Timing
- Grant latency: 0 cycles (same cycle as `Req`) when uncontested.
- Read latency: the `Valid` pulse arrives 1 cycle after `Gnt`.
- Throughput: one access per cycle. Back-to-back reads from alternating ports produce interleaved `Valid` pulses with no bubble.
- Worst-case fetch wait under continuous port 0 traffic: `STARVE_MAX` denied cycles, then a grant on the next cycle.
- Reset, on the edge where `rst = 1`:
  - `starve = 0`, `rspTag = NONE`.
  - `m0Valid = m1Valid = 0`.
  - `m0RData = m1RData = 0`, `memAddr = 0`.
- While `rst = 1`:
  - `m0Gnt = m1Gnt = 0` and `memWrite = 0`; requests are ignored.
- A read granted in the cycle `rst` rises gets no `Valid` pulse. The read is dropped and the requester must re-issue it.
- Simultaneous store (port 0) and fetch to the same address: port 0 wins unless starving. A later fetch returns the new data.

## Test plan
1. Reset, then `m1Req = 1`, `m1Addr = 0x10` with memory[0x10] = 0xDEADBEEF → `m1Gnt = 1` the same cycle; next cycle `m1Valid = 1`, `m1RData = 0xDEADBEEF`; `m0Valid` stays 0.
2. Port 0 store: `m0Write = 1`, `m0Addr = 0x20`, `m0Data = 0x12345678` → `memWrite = 1` for exactly one cycle, no `m0Valid`. A following port 0 load of 0x20 → `m0Valid` with `m0RData = 0x12345678`.
3. Contention with `STARVE_MAX = 4`: `m0Req` and `m1Req` held high for 10 cycles, port 0 re-requesting every cycle. Grant pattern must be 0,0,0,0,1,0,0,0,0,1; `starve` clears after each port 1 grant.
4. Alternating grants 0-load, 1-read, 0-load → `Valid` pulses on 0, 1, 0 in consecutive cycles, each carrying its own address's data. `m0RData` is held unchanged during the port 1 pulse.
5. Assert `rst` in the cycle `m1Gnt = 1` → no `m1Valid` next cycle, all outputs at reset values, `starve = 0`. After deassertion, a re-issued read completes normally.
6. No requests for 5 cycles → `memWrite = 0`, both `Gnt` = 0, both `Valid` = 0; `RData` outputs keep their last values.
